// File: rtl/vai_mmio_initiator.sv
// Host-side CCI-P MMIO initiator: one outstanding read or posted write, tid tagged,
// read responses matched by tid, with a response timeout and stale/timeout counters.
module vai_mmio_initiator #(
   parameter int TIMEOUT_CYCLES = 512,
   parameter int ADDR_WIDTH     = 16,
   parameter int TID_WIDTH      = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [63:0]           cmd_wdata,
   output logic                  mmio_rd_valid,
   output logic                  mmio_wr_valid,
   output logic [ADDR_WIDTH-1:0] mmio_addr,
   output logic [TID_WIDTH-1:0]  mmio_tid,
   output logic [63:0]           mmio_data,
   input  logic                  rsp_valid,
   input  logic [TID_WIDTH-1:0]  rsp_tid,
   input  logic [63:0]           rsp_data,
   output logic                  done_valid,
   output logic [63:0]           done_data,
   output logic                  done_err,
   output logic [15:0]           stale_cnt,
   output logic [15:0]           timeout_cnt
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

   state_t               state, state_next;
   logic [TID_WIDTH-1:0] tid_ctr;
   logic [WAIT_W-1:0]    wait_ctr;
   logic                 is_write;
   logic                 accept, rsp_match, rsp_stale, timeout, wr_done;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      accept     = 1'b0;
      rsp_match  = 1'b0;
      rsp_stale  = 1'b0;
      timeout    = 1'b0;
      wr_done    = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = !reset;
            rsp_stale = rsp_valid;
            if (cmd_valid && !reset) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            rsp_stale  = rsp_valid;
            wr_done    = is_write;
            state_next = is_write ? IDLE : WAIT_RSP;
         end
         WAIT_RSP: begin
            // A match in the final wait cycle takes priority over the timeout.
            if (rsp_valid && rsp_tid == mmio_tid) begin
               rsp_match  = 1'b1;
               state_next = IDLE;
            end else begin
               rsp_stale = rsp_valid;
               if (wait_ctr == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout    = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // wait_ctr starts at the strobe cycle so the timeout completes at cycle 1+TIMEOUT_CYCLES.
   always_ff @(posedge clk) begin
      if (reset) begin
         tid_ctr       <= '0;
         wait_ctr      <= '0;
         is_write      <= 1'b0;
         mmio_rd_valid <= 1'b0;
         mmio_wr_valid <= 1'b0;
         mmio_addr     <= '0;
         mmio_tid      <= '0;
         mmio_data     <= '0;
         done_valid    <= 1'b0;
         done_data     <= '0;
         done_err      <= 1'b0;
         stale_cnt     <= '0;
         timeout_cnt   <= '0;
      end else begin
         mmio_rd_valid <= accept && !cmd_write;
         mmio_wr_valid <= accept && cmd_write;
         done_valid    <= wr_done || rsp_match || timeout;

         if (accept) begin
            is_write  <= cmd_write;
            mmio_addr <= cmd_addr & ~ADDR_WIDTH'(1);
            mmio_tid  <= tid_ctr;
            mmio_data <= cmd_write ? cmd_wdata : 64'd0;
            tid_ctr   <= tid_ctr + TID_WIDTH'(1);
            wait_ctr  <= '0;
         end else if (state != IDLE) begin
            wait_ctr <= wait_ctr + WAIT_W'(1);
         end

         if (wr_done) begin
            done_data <= 64'd0;
            done_err  <= 1'b0;
         end else if (rsp_match) begin
            done_data <= rsp_data;
            done_err  <= 1'b0;
         end else if (timeout) begin
            done_data <= {64{1'b1}};
            done_err  <= 1'b1;
         end

         if (rsp_stale && stale_cnt != 16'hFFFF)
            stale_cnt <= stale_cnt + 16'd1;
         if (timeout && timeout_cnt != 16'hFFFF)
            timeout_cnt <= timeout_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vai_mmio_initiator.sv
// Randomized self-checking bench for vai_mmio_initiator against a transaction-level
// model of tid allocation, completion timing and stale/timeout accounting.
module tb_vai_mmio_initiator;

   localparam int TMO = 16;
   localparam int AW  = 16;
   localparam int TW  = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [63:0]   cmd_wdata;
   logic          mmio_rd_valid, mmio_wr_valid;
   logic [AW-1:0] mmio_addr;
   logic [TW-1:0] mmio_tid;
   logic [63:0]   mmio_data;
   logic          rsp_valid;
   logic [TW-1:0] rsp_tid;
   logic [63:0]   rsp_data;
   logic          done_valid, done_err;
   logic [63:0]   done_data;
   logic [15:0]   stale_cnt, timeout_cnt;

   vai_mmio_initiator #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(AW), .TID_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
      .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
      .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
      .done_valid(done_valid), .done_data(done_data), .done_err(done_err),
      .stale_cnt(stale_cnt), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [TW-1:0] m_tid;
   int            m_stale, m_tmo;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   // One command: accepted in the current cycle (cycle 0). rsp_at is the cycle of the
   // matching response (>TMO or <2 means none); stale_at marks cycles carrying a stale one.
   task automatic access(input bit wr, input logic [AW-1:0] addr, input logic [63:0] wdata,
                         input int rsp_at, input logic [63:0] rdata, input logic [31:0] stale_at,
                         input bit fixed_stale, input logic [TW-1:0] stale_tid, input bit late);
      logic [TW-1:0] tid;
      bit            match;
      int            done;
      tid   = m_tid;
      match = !wr && rsp_at >= 2 && rsp_at <= TMO;
      done  = wr ? 2 : (match ? rsp_at + 1 : TMO + 1);

      chk("ready_idle", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      tick();
      cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = AW'($urandom); cmd_wdata = {$urandom, $urandom};
      m_tid = m_tid + TW'(1);

      chk("rd_strobe", 64'(mmio_rd_valid), 64'(!wr));
      chk("wr_strobe", 64'(mmio_wr_valid), 64'(wr));
      chk("req_addr", 64'(mmio_addr), 64'(addr & 16'hFFFE));
      chk("req_tid", 64'(mmio_tid), 64'(tid));
      chk("req_data", mmio_data, wr ? wdata : 64'd0);
      chk("ready_busy", 64'(cmd_ready), 64'd0);
      chk("stale_pre", 64'(stale_cnt), 64'(m_stale));
      chk("tmo_pre", 64'(timeout_cnt), 64'(m_tmo));

      for (int c = 1; c < done; c++) begin
         rsp_valid = 1'b0;
         if (match && c == rsp_at) begin
            rsp_valid = 1'b1; rsp_tid = tid; rsp_data = rdata;
         end else if (stale_at[c]) begin
            rsp_valid = 1'b1;
            rsp_data  = {$urandom, $urandom};
            if (c == 1)           rsp_tid = TW'($urandom);
            else if (fixed_stale) rsp_tid = stale_tid;
            else                  rsp_tid = tid ^ TW'($urandom_range(1, 511));
            m_stale = sat(m_stale + 1);
         end
         tick();
         rsp_valid = 1'b0;
         if (c + 1 < done) begin
            chk("no_done", 64'(done_valid), 64'd0);
            chk("no_strobe", 64'(mmio_rd_valid | mmio_wr_valid), 64'd0);
            chk("ready_wait", 64'(cmd_ready), 64'd0);
         end
      end

      if (!wr && !match) m_tmo = sat(m_tmo + 1);
      chk("done_valid", 64'(done_valid), 64'd1);
      chk("done_data", done_data, wr ? 64'd0 : (match ? rdata : {64{1'b1}}));
      chk("done_err", 64'(done_err), 64'(!wr && !match));
      chk("ready_done", 64'(cmd_ready), 64'd1);
      chk("stale_cnt", 64'(stale_cnt), 64'(m_stale));
      chk("timeout_cnt", 64'(timeout_cnt), 64'(m_tmo));

      if (late) begin
         rsp_valid = 1'b1; rsp_tid = tid; rsp_data = {$urandom, $urandom};
         m_stale = sat(m_stale + 1);
         tick();
         rsp_valid = 1'b0;
         chk("late_no_done", 64'(done_valid), 64'd0);
         chk("late_stale", 64'(stale_cnt), 64'(m_stale));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_tid = '0; m_stale = 0; m_tmo = 0;
      tick();
   endtask

   logic [TW-1:0] old_tid;
   bit            r_wr, r_late;
   int            r_at;
   logic [31:0]   r_mask;

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_valid = 1'b0; rsp_tid = '0; rsp_data = '0;
      m_tid = '0; m_stale = 0; m_tmo = 0;
      tick();
      tick();
      chk("rst_ready", 64'(cmd_ready), 64'd0);
      chk("rst_strobes", 64'({mmio_rd_valid, mmio_wr_valid, done_valid, done_err}), 64'd0);
      chk("rst_req", 64'({mmio_addr, mmio_tid}), 64'd0);
      chk("rst_mdata", mmio_data, 64'd0);
      chk("rst_ddata", done_data, 64'd0);
      chk("rst_cnts", 64'({stale_cnt, timeout_cnt}), 64'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);

      // Directed cases
      access(1'b1, 16'h000C, 64'hDEAD_BEEF_0000_0001, 0, 64'd0, 32'd0, 1'b0, '0, 1'b0);
      access(1'b0, 16'h0010, 64'd0, 4, 64'h55, 32'd0, 1'b0, '0, 1'b0);
      access(1'b0, 16'h0020, 64'd0, 6, 64'h0123_4567_89AB_CDEF, 32'h8, 1'b1, 9'h1F0, 1'b0);
      access(1'b0, 16'h0030, 64'd0, 0, 64'd0, 32'd0, 1'b0, '0, 1'b1);
      access(1'b0, 16'h0032, 64'd0, TMO, 64'h77, 32'h1_0002, 1'b0, '0, 1'b0);

      // Reset while a read waits
      chk("ready_before_abort", 64'(cmd_ready), 64'd1);
      old_tid   = m_tid;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040;
      tick();
      cmd_valid = 1'b0;
      chk("abort_tid", 64'(mmio_tid), 64'(old_tid));
      tick();
      tick();
      chk("abort_wait", 64'(done_valid), 64'd0);
      reset = 1'b1;
      tick();
      chk("abort_in_rst", 64'({done_valid, cmd_ready}), 64'd0);
      reset = 1'b0;
      m_tid = '0; m_stale = 0; m_tmo = 0;
      tick();
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      chk("abort_no_done", 64'(done_valid), 64'd0);
      chk("abort_cnts", 64'({stale_cnt, timeout_cnt}), 64'd0);
      rsp_valid = 1'b1; rsp_tid = old_tid; rsp_data = 64'h99;
      m_stale = 1;
      tick();
      rsp_valid = 1'b0;
      chk("abort_late_no_done", 64'(done_valid), 64'd0);
      chk("abort_late_stale", 64'(stale_cnt), 64'(m_stale));
      access(1'b0, 16'h0050, 64'd0, 3, 64'hA5A5, 32'd0, 1'b0, '0, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_at   = $urandom_range(2, TMO + 3);
         r_late = (!r_wr && r_at > TMO) ? 1'($urandom_range(0, 1)) : 1'b0;
         r_mask = $urandom & $urandom & 32'h0001_FFFE;
         access(r_wr, AW'($urandom), {$urandom, $urandom}, r_at, {$urandom, $urandom},
                r_mask, 1'b0, '0, r_late);
         repeat ($urandom_range(0, 2)) begin
            tick();
            chk("gap_no_done", 64'(done_valid), 64'd0);
         end
      end

      // Tid wrap, then an odd read address
      do_reset();
      for (int i = 0; i < 513; i++)
         access(1'b1, AW'($urandom), {$urandom, $urandom}, 0, 64'd0, 32'd0, 1'b0, '0, 1'b0);
      access(1'b0, 16'h0007, 64'd0, 5, 64'hC0FFEE, 32'd0, 1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vai_mmio_initiator.md
# vai_mmio_initiator

Generates host-style CCI-P MMIO read and write requests from a simple command port and collects the matching MMIO read responses. It is the requesting end of the MMIO protocol that the VAI manager and the sub-AFUs answer. In the nested VAI mux, a parent level uses it to program a child manager's control registers (offsets, sub-AFU resets, DFH/ID probes). It bench-models the host side of the same path. One access is outstanding at a time, with tid tagging, response matching and a timeout.

## Interface
- TIMEOUT_CYCLES, 512: cycles to wait for a read response before reporting an error; minimum 2.
- ADDR_WIDTH, 16: MMIO DW-address width, equal to CCIP_MMIOADDR_WIDTH.
- TID_WIDTH, 9: MMIO transaction-id width, equal to the CCI-P tid width.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  DW address
- cmd_wdata  in  64  write data
- mmio_rd_valid  out  1  MMIO read request strobe (toward responder, c0 mmioRdValid)
- mmio_wr_valid  out  1  MMIO write request strobe (c0 mmioWrValid)
- mmio_addr  out  ADDR_WIDTH  request address
- mmio_tid  out  TID_WIDTH  request tid
- mmio_data  out  64  write data; 0 for reads
- rsp_valid  in  1  MMIO read response strobe (c2 mmioRdValid)
- rsp_tid  in  TID_WIDTH  response tid
- rsp_data  in  64  response data
- done_valid  out  1  one-cycle completion pulse
- done_data  out  64  read data; 0 for writes
- done_err  out  1  completion was a timeout
- stale_cnt  out  16  saturating count of dropped responses
- timeout_cnt  out  16  saturating count of timeouts

## Operation
- **States:** IDLE, ISSUE, WAIT_RSP.
- **IDLE**
  - cmd_ready = 1 in IDLE only.
  - On cmd_valid&cmd_ready: latch write flag, address with bit 0 forced to 0 (64-bit access only), and wdata. Go to ISSUE.
- **ISSUE** (one cycle)
  - Registered mmio_rd_valid or mmio_wr_valid is high for exactly this cycle, with mmio_addr, mmio_tid = tid_ctr, and mmio_data (0 for reads).
  - tid_ctr increments on every issued request and wraps from 2^TID_WIDTH-1 to 0.
  - Write: next state IDLE; done_valid=1, done_data=0, done_err=0 in the following cycle (writes are posted).
  - Read: next state WAIT_RSP; clear wait_ctr.
- **WAIT_RSP**
  - wait_ctr increments each cycle.
  - rsp_valid with rsp_tid equal to the issued tid: capture rsp_data and go to IDLE. Next cycle: done_valid=1, done_data=rsp_data, done_err=0.
  - rsp_valid with any other tid: drop the response and increment stale_cnt.
  - wait_ctr reaching TIMEOUT_CYCLES-1 with no match: go to IDLE. Next cycle: done_valid=1, done_data=64'hFFFF_FFFF_FFFF_FFFF, done_err=1; timeout_cnt increments.
  - A matching response in that same final cycle wins; no timeout is reported.
- Any rsp_valid in IDLE or ISSUE is stale and increments stale_cnt.
- A late response to a timed-out tid is stale.
- Both counters saturate at 16'hFFFF.
- **Reset values:** state IDLE, tid_ctr 0, wait_ctr 0. All outputs 0 except cmd_ready, which is 1 in the cycle after reset deasserts.
- **Reset mid-operation:** abort with no done pulse and no counter update. A later response to the aborted tid counts as stale.

## Timing
- Command accepted at cycle 0 → request strobe at cycle 1.
- Write: done_valid at cycle 2; cmd_ready high again at cycle 2, so write-to-write throughput is 1 per 2 cycles.
- Read: matching response at cycle N ≥ 2 → done_valid at N+1, with cmd_ready high in that same cycle.
- Timeout: done_valid at cycle 1+TIMEOUT_CYCLES.
- done_valid has no backpressure. It pulses exactly once per accepted command and never twice in consecutive cycles.
- Request outputs hold their last values while strobes are low, except mmio_data, which is 0 for reads.

## Test plan
- **Write, addr 0x000C, data 0xDEAD_BEEF_0000_0001**
  - Stimulus: command accepted at cycle 0.
  - Required: mmio_wr_valid at cycle 1 with tid 0 and addr 0x000C; done_valid at cycle 2 with data 0, err 0.
- **Read, addr 0x0010; responder returns tid 1, data 0x55 after 3 cycles**
  - Stimulus: issue after one prior access; response arrives at cycle 4.
  - Required: done_valid at cycle 5, done_data 0x55, stale_cnt unchanged.
- **Read with a wrong-tid response before the correct one**
  - Stimulus: rsp tid 0x1F0, then the correct tid.
  - Required: stale_cnt=1; done_data equals the correct response.
- **Read with no response, TIMEOUT_CYCLES=16**
  - Stimulus: no rsp_valid after issue.
  - Required: done_err=1 and data all-ones at cycle 17; timeout_cnt=1. A late response afterwards gives stale_cnt=1.
- **Tid wrap and odd address**
  - Stimulus: 513 back-to-back writes, then a read to addr 0x0007.
  - Required: tids go 0..511, 0; the read issues on addr 0x0006 with tid 1.
- **Reset during WAIT_RSP**
  - Stimulus: assert reset while a read is waiting.
  - Required: no done_valid; cmd_ready=1 after reset; tid restarts at 0.
